sha256_msg_schedule: RTL and testbench



---
 rtl/sha256_pkg.sv | 24 ++
 rtl/sha256_sched_window.sv | 32 +++
 rtl/sha256_msg_schedule.sv | 85 ++++++++
 tb/tb_sha256_msg_schedule.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sha256_pkg.sv
// rtl/sha256_pkg.sv - shared SHA-256 constants, schedule states and sigma helpers
package sha256_pkg;

  localparam int WORD_W     = 32;
  localparam int ROUNDS     = 64;
  localparam int LOAD_WORDS = 16;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_EXPAND = 3'd2,
    ST_DRAIN  = 3'd3,
    ST_DONE   = 3'd4
  } sched_state_e;

  function automatic logic [WORD_W-1:0] s0(input logic [WORD_W-1:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
  endfunction

  function automatic logic [WORD_W-1:0] s1(input logic [WORD_W-1:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
  endfunction

endpackage

// File: rtl/sha256_sched_window.sv
// rtl/sha256_sched_window.sv - 16-word sliding window feeding the schedule recurrence
module sha256_sched_window
  import sha256_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [WORD_W-1:0] din,
  output logic [WORD_W-1:0] tap0,
  output logic [WORD_W-1:0] tap1,
  output logic [WORD_W-1:0] tap9,
  output logic [WORD_W-1:0] tap14
);

  // win_q[LOAD_WORDS-1] holds the newest word, win_q[0] the oldest (W[t-16])
  logic [WORD_W-1:0] win_q [LOAD_WORDS];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < LOAD_WORDS; i++) win_q[i] <= '0;
    end else if (push) begin
      for (int i = 0; i < LOAD_WORDS - 1; i++) win_q[i] <= win_q[i+1];
      win_q[LOAD_WORDS-1] <= din;
    end
  end

  assign tap0  = win_q[0];
  assign tap1  = win_q[1];
  assign tap9  = win_q[9];
  assign tap14 = win_q[14];

endmodule

// File: rtl/sha256_msg_schedule.sv
// rtl/sha256_msg_schedule.sv - SHA-256 message schedule: loads W0..W15, expands W16..W63
module sha256_msg_schedule
  import sha256_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              w_valid,
  input  logic [WORD_W-1:0] w_in,
  output logic              w_ready,
  output logic [WORD_W-1:0] wt_o,
  output logic [5:0]        wt_idx_o,
  output logic              wt_valid_o,
  input  logic              wt_ready,
  output logic              busy_o,
  output logic              done_o
);

  sched_state_e      state_q, state_d;
  logic [6:0]        t_q;
  logic              adv, accept, issue_exp, push;
  logic [WORD_W-1:0] tap0, tap1, tap9, tap14;
  logic [WORD_W-1:0] wt_calc, push_data;

  // Output register may take a new word only when empty or being consumed
  assign adv       = !wt_valid_o || wt_ready;
  assign w_ready   = (state_q == ST_LOAD) && adv;
  assign accept    = w_valid && w_ready;
  assign issue_exp = (state_q == ST_EXPAND) && adv;
  assign push      = accept || issue_exp;

  assign wt_calc   = s1(tap14) + tap9 + s0(tap1) + tap0;
  assign push_data = (state_q == ST_LOAD) ? w_in : wt_calc;

  assign busy_o = (state_q == ST_LOAD) || (state_q == ST_EXPAND) || (state_q == ST_DRAIN);
  assign done_o = (state_q == ST_DONE);

  sha256_sched_window u_window (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (push_data),
    .tap0  (tap0),
    .tap1  (tap1),
    .tap9  (tap9),
    .tap14 (tap14)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (start) state_d = ST_LOAD;
      ST_LOAD:   if (accept && t_q == 7'(LOAD_WORDS - 1)) state_d = ST_EXPAND;
      ST_EXPAND: if (issue_exp && t_q == 7'(ROUNDS - 1)) state_d = ST_DRAIN;
      ST_DRAIN:  if (wt_valid_o && wt_ready) state_d = ST_DONE;
      ST_DONE:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      t_q        <= '0;
      wt_o       <= '0;
      wt_idx_o   <= '0;
      wt_valid_o <= 1'b0;
    end else begin
      if (state_q == ST_IDLE && start) t_q <= '0;
      if (push) begin
        wt_o       <= push_data;
        wt_idx_o   <= t_q[5:0];
        wt_valid_o <= 1'b1;
        t_q        <= t_q + 7'd1;
      end else if (adv) begin
        wt_valid_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sha256_msg_schedule.sv
// tb/tb_sha256_msg_schedule.sv - self-checking bench for sha256_msg_schedule
module tb_sha256_msg_schedule;

  logic        clk = 1'b0;
  logic        rst, start, w_valid, w_ready, wt_valid_o, wt_ready, busy_o, done_o;
  logic [31:0] w_in, wt_o;
  logic [5:0]  wt_idx_o;

  sha256_msg_schedule dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .w_valid    (w_valid),
    .w_in       (w_in),
    .w_ready    (w_ready),
    .wt_o       (wt_o),
    .wt_idx_o   (wt_idx_o),
    .wt_valid_o (wt_valid_o),
    .wt_ready   (wt_ready),
    .busy_o     (busy_o),
    .done_o     (done_o)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          idx;
    logic [31:0] exp;
  } vec_t;
  vec_t abc_tbl [7];

  logic [31:0] blk [16];
  logic [31:0] exp_w [64];
  logic [31:0] got_w [$];
  logic [5:0]  got_i [$];
  int          got_c [$];
  int          done_cnt, done_cyc, hs63_cyc, wready_cnt;
  bit          rand_ready = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] ref_s0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] ref_s1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  task automatic build_model();
    for (int t = 0; t < 16; t++) exp_w[t] = blk[t];
    for (int t = 16; t < 64; t++)
      exp_w[t] = ref_s1(exp_w[t-2]) + exp_w[t-7] + ref_s0(exp_w[t-15]) + exp_w[t-16];
  endtask

  task automatic load_abc(input logic [31:0] last);
    for (int i = 0; i < 16; i++) blk[i] = 32'h0;
    blk[0]  = 32'h61626380;
    blk[15] = last;
  endtask

  // downstream ready: held high or ~50% random
  initial begin
    wt_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      wt_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // output monitor: handshakes, stall stability, done pulses
  initial begin
    bit          prev_stall = 1'b0;
    logic [31:0] prev_w = '0;
    logic [5:0]  prev_i = '0;
    forever begin
      @(negedge clk);
      if (rst) prev_stall = 1'b0;
      else begin
        if (prev_stall)
          chk("stall_hold", {25'd0, wt_valid_o, wt_idx_o, wt_o}, {25'd0, 1'b1, prev_i, prev_w});
        if (wt_valid_o && wt_ready) begin
          got_w.push_back(wt_o);
          got_i.push_back(wt_idx_o);
          got_c.push_back(cyc);
          if (wt_idx_o == 6'd63) hs63_cyc = cyc;
        end
        if (done_o) begin
          done_cnt++;
          done_cyc = cyc;
        end
        if (w_ready) wready_cnt++;
        prev_stall = wt_valid_o && !wt_ready;
        prev_w = wt_o;
        prev_i = wt_idx_o;
      end
    end
  end

  task automatic send_block(input bit gaps);
    bit acc;
    for (int i = 0; i < 16; i++) begin
      if (gaps && (i % 3 == 1)) begin
        w_valid = 1'b0;
        w_in = $urandom;
        @(posedge clk); #1;
      end
      w_valid = 1'b1;
      w_in = blk[i];
      acc = 1'b0;
      for (int n = 0; n < 200 && !acc; n++) begin
        @(negedge clk);
        acc = w_ready;
        @(posedge clk); #1;
      end
      if (!acc) chk("load_timeout", 64'd0, 64'd1);
    end
    w_valid = 1'b0;
  endtask

  task automatic wait_idx(input logic [5:0] idx);
    bit seen = 1'b0;
    for (int n = 0; n < 2000 && !seen; n++) begin
      @(negedge clk);
      seen = wt_valid_o && (wt_idx_o == idx);
    end
    if (!seen) chk("wait_idx_timeout", 64'd0, 64'd1);
  endtask

  // mode 0: plain block; 1: re-pulse start at t=30; 2: async reset at t=40
  task automatic run_block(input int mode, input bit gaps, input bit hold_valid);
    got_w.delete(); got_i.delete(); got_c.delete();
    done_cnt = 0; wready_cnt = 0; hs63_cyc = -100; done_cyc = -1;
    build_model();
    @(posedge clk); #1; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    send_block(gaps);
    if (hold_valid) begin
      w_valid = 1'b1;
      w_in = $urandom;
    end
    if (mode == 1) begin
      wait_idx(6'd30);
      @(posedge clk); #1; start = 1'b1;
      @(posedge clk); #1; start = 1'b0;
    end
    if (mode == 2) begin
      wait_idx(6'd40);
      #2 rst = 1'b1;
      #1;
      chk("rst_wt_o", 64'(wt_o), 64'd0);
      chk("rst_wt_idx_o", 64'(wt_idx_o), 64'd0);
      chk("rst_wt_valid_o", 64'(wt_valid_o), 64'd0);
      chk("rst_w_ready", 64'(w_ready), 64'd0);
      chk("rst_busy_o", 64'(busy_o), 64'd0);
      chk("rst_done_o", 64'(done_o), 64'd0);
      @(negedge clk); rst = 1'b0;
      @(posedge clk); #1; w_valid = 1'b1; w_in = 32'hA5A5A5A5;
      repeat (3) begin
        @(negedge clk);
        chk("idle_after_rst", {61'd0, w_ready, busy_o, wt_valid_o}, 64'd0);
      end
      w_valid = 1'b0;
    end else begin
      for (int n = 0; n < 2000 && done_cnt == 0; n++) @(negedge clk);
      repeat (3) @(negedge clk);
      w_valid = 1'b0;
      chk("word_count", 64'(got_w.size()), 64'd64);
      for (int k = 0; k < 64 && k < got_w.size(); k++) begin
        chk($sformatf("idx[%0d]", k), 64'(got_i[k]), 64'(k));
        chk($sformatf("wt[%0d]", k), 64'(got_w[k]), 64'(exp_w[k]));
      end
      chk("done_pulses", 64'(done_cnt), 64'd1);
      chk("done_timing", 64'(done_cyc), 64'(hs63_cyc + 1));
    end
  endtask

  task automatic check_abc_table();
    for (int j = 0; j < 7; j++)
      if (abc_tbl[j].idx < got_w.size())
        chk($sformatf("abc_tbl[%0d]", abc_tbl[j].idx), 64'(got_w[abc_tbl[j].idx]), 64'(abc_tbl[j].exp));
      else
        chk($sformatf("abc_missing[%0d]", abc_tbl[j].idx), 64'd0, 64'd1);
  endtask

  initial begin
    abc_tbl[0] = '{0,  32'h61626380};
    abc_tbl[1] = '{1,  32'h00000000};
    abc_tbl[2] = '{14, 32'h00000000};
    abc_tbl[3] = '{15, 32'h00000018};
    abc_tbl[4] = '{16, 32'h61626380};
    abc_tbl[5] = '{17, 32'h000F0000};
    abc_tbl[6] = '{18, 32'h7DA86405};

    rst = 1'b1; start = 1'b0; w_valid = 1'b0; w_in = '0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", {24'd0, wt_o, wt_idx_o, wt_valid_o, w_ready, busy_o, done_o}, 64'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_outputs", {61'd0, w_ready, busy_o, done_o}, 64'd0);

    // "abc" block with wt_ready held high
    load_abc(32'h00000018);
    run_block(0, 1'b0, 1'b0);
    check_abc_table();

    // throughput: w_valid held high, including idle cycles where it must be ignored
    @(posedge clk); #1; w_valid = 1'b1; w_in = 32'hDEADBEEF;
    repeat (3) begin
      @(negedge clk);
      chk("idle_w_ready", {62'd0, w_ready, wt_valid_o}, 64'd0);
    end
    for (int i = 0; i < 16; i++) blk[i] = $urandom;
    run_block(0, 1'b0, 1'b1);
    if (got_c.size() >= 64) chk("burst_span", 64'(got_c[63] - got_c[0]), 64'd63);
    chk("w_ready_cycles", 64'(wready_cnt), 64'd16);

    // backpressure on "abc"
    rand_ready = 1'b1;
    load_abc(32'h00000018);
    run_block(0, 1'b0, 1'b0);
    check_abc_table();
    rand_ready = 1'b0;

    // upstream gaps on "abc"
    load_abc(32'h00000018);
    run_block(0, 1'b1, 1'b0);
    check_abc_table();

    // start re-pulsed mid-expansion is ignored
    load_abc(32'h00000018);
    run_block(1, 1'b0, 1'b0);
    check_abc_table();

    // fresh block with W15=0
    load_abc(32'h00000000);
    run_block(0, 1'b0, 1'b0);
    if (got_w.size() > 17) chk("w15zero_W17", 64'(got_w[17]), 64'd0);

    // async reset mid-block, then recovery
    load_abc(32'h00000018);
    run_block(2, 1'b0, 1'b0);
    run_block(0, 1'b0, 1'b0);
    check_abc_table();

    // random blocks with random backpressure and gaps
    rand_ready = 1'b1;
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 16; i++) blk[i] = $urandom;
      run_block(0, 1'(r % 2), 1'b0);
    end
    rand_ready = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
